// File: rtl/dma_perf_monitor.sv
// dma_perf_monitor: timing monitor for a set of PCIe DMA write channels.
// Each channel runs an IDLE/BUSY/GAP tracker that measures transfer length
// (start..end) and idle gap (end..next start). It also keeps last/min/max
// busy length, max gap, a transfer count, and sticky error/saturation bits.
// All counters and statistics saturate at all-ones and never wrap.
//
// Read port handshake: the requester pulses rd_en with rd_ch/rd_sel for one
// cycle. On the following cycle rd_valid is high for exactly one cycle, and
// rd_data carries the value the statistic had when rd_en was sampled. There
// is no backpressure. rd_data keeps its last value while rd_valid is low.
module dma_perf_monitor #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int CH_W   = 4
) (
   input  logic              clk_pcie,
   input  logic              rst_pcie,
   input  logic [NUM_CH-1:0] dma_write_start,
   input  logic [NUM_CH-1:0] dma_write_end,
   input  logic              stat_clear,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [2:0]        rd_sel,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              test_interval
);

   // The status read exposes these encodings directly as state[1:0].
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] ONES = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_e            state_q     [NUM_CH];
   logic [CNT_W-1:0]  busy_cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  gap_cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  busy_last_q [NUM_CH];
   logic [CNT_W-1:0]  busy_min_q  [NUM_CH];
   logic [CNT_W-1:0]  busy_max_q  [NUM_CH];
   logic [CNT_W-1:0]  gap_max_q   [NUM_CH];
   logic [CNT_W-1:0]  xfer_cnt_q  [NUM_CH];
   logic [NUM_CH-1:0] err_q;
   logic [NUM_CH-1:0] sat_q;

   logic [CNT_W-1:0]  busy_len [NUM_CH];
   logic [CNT_W-1:0]  gap_len  [NUM_CH];
   logic [NUM_CH-1:0] rec_busy;
   logic [NUM_CH-1:0] rec_gap;
   logic [NUM_CH-1:0] err_set;
   logic [NUM_CH-1:0] sat_set;

   logic [CNT_W-1:0]  rd_data_q, rd_data_d;
   logic              rd_valid_q;
   logic              test_interval_q, test_interval_d;

   // Decode per-channel events and the saturated lengths that would be recorded
   always_comb begin
      busy_len = '{default: '0};
      gap_len  = '{default: '0};
      rec_busy = '0;
      rec_gap  = '0;
      err_set  = '0;
      sat_set  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         busy_len[c] = (busy_cnt_q[c] == ONES) ? ONES : busy_cnt_q[c] + ONE;
         gap_len[c]  = (gap_cnt_q[c] == ONES) ? ONES : gap_cnt_q[c] + ONE;
         rec_busy[c] = (state_q[c] == ST_BUSY) && dma_write_end[c];
         rec_gap[c]  = (state_q[c] == ST_GAP) && dma_write_start[c];
         err_set[c]  = (state_q[c] == ST_BUSY) && dma_write_start[c] && !dma_write_end[c];
         // A full counter overflows when it would increment or be recorded
         // as length+1. A restart after an error drops the count instead.
         sat_set[c]  = ((state_q[c] == ST_BUSY) && (busy_cnt_q[c] == ONES) &&
                        (dma_write_end[c] || !dma_write_start[c])) ||
                       ((state_q[c] == ST_GAP) && (gap_cnt_q[c] == ONES)) ||
                       (rec_busy[c] && (xfer_cnt_q[c] == ONES));
      end
   end

   // Per-channel FSM, running counters, and statistics
   always_ff @(posedge clk_pcie or posedge rst_pcie) begin
      if (rst_pcie) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]     <= ST_IDLE;
            busy_cnt_q[c]  <= '0;
            gap_cnt_q[c]   <= '0;
            busy_last_q[c] <= '0;
            busy_min_q[c]  <= ONES;
            busy_max_q[c]  <= '0;
            gap_max_q[c]   <= '0;
            xfer_cnt_q[c]  <= '0;
         end
         err_q <= '0;
         sat_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
               ST_IDLE: begin
                  if (dma_write_start[c]) begin
                     state_q[c]    <= ST_BUSY;
                     busy_cnt_q[c] <= '0;
                  end
               end
               ST_BUSY: begin
                  if (dma_write_end[c]) begin
                     // A same-cycle start begins the next transfer with no gap.
                     if (dma_write_start[c]) begin
                        busy_cnt_q[c] <= '0;
                     end else begin
                        state_q[c]   <= ST_GAP;
                        gap_cnt_q[c] <= '0;
                     end
                  end else if (dma_write_start[c]) begin
                     busy_cnt_q[c] <= '0;
                  end else if (busy_cnt_q[c] != ONES) begin
                     busy_cnt_q[c] <= busy_cnt_q[c] + ONE;
                  end
               end
               ST_GAP: begin
                  if (dma_write_start[c]) begin
                     state_q[c]    <= ST_BUSY;
                     busy_cnt_q[c] <= '0;
                  end else if (gap_cnt_q[c] != ONES) begin
                     gap_cnt_q[c] <= gap_cnt_q[c] + ONE;
                  end
               end
               default: state_q[c] <= ST_IDLE;
            endcase

            if (stat_clear) begin
               busy_last_q[c] <= '0;
               busy_min_q[c]  <= ONES;
               busy_max_q[c]  <= '0;
               gap_max_q[c]   <= '0;
               xfer_cnt_q[c]  <= '0;
               err_q[c]       <= 1'b0;
               sat_q[c]       <= 1'b0;
            end else begin
               if (rec_busy[c]) begin
                  busy_last_q[c] <= busy_len[c];
                  if (busy_len[c] < busy_min_q[c]) busy_min_q[c] <= busy_len[c];
                  if (busy_len[c] > busy_max_q[c]) busy_max_q[c] <= busy_len[c];
                  if (xfer_cnt_q[c] != ONES) xfer_cnt_q[c] <= xfer_cnt_q[c] + ONE;
               end
               if (rec_gap[c] && (gap_len[c] > gap_max_q[c])) gap_max_q[c] <= gap_len[c];
               if (err_set[c]) err_q[c] <= 1'b1;
               if (sat_set[c]) sat_q[c] <= 1'b1;
            end
         end
      end
   end

   // Select the requested statistic; out-of-range channel or select reads 0
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
               case (rd_sel)
                  3'd0: rd_data_d = busy_last_q[c];
                  3'd1: rd_data_d = busy_min_q[c];
                  3'd2: rd_data_d = busy_max_q[c];
                  3'd3: rd_data_d = gap_max_q[c];
                  3'd4: rd_data_d = xfer_cnt_q[c];
                  3'd5: rd_data_d = {{(CNT_W-4){1'b0}}, sat_q[c], err_q[c], state_q[c]};
                  default: rd_data_d = '0;
               endcase
            end
         end
      end
   end

   // No activity recorded yet: every busy_max and gap_max is still zero
   always_comb begin
      test_interval_d = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
         if ((busy_max_q[c] != '0) || (gap_max_q[c] != '0)) test_interval_d = 1'b0;
      end
   end

   // Register the read port and the activity flag
   always_ff @(posedge clk_pcie or posedge rst_pcie) begin
      if (rst_pcie) begin
         rd_data_q       <= '0;
         rd_valid_q      <= 1'b0;
         test_interval_q <= 1'b1;
      end else begin
         rd_data_q       <= rd_data_d;
         rd_valid_q      <= rd_en;
         test_interval_q <= test_interval_d;
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;
   assign test_interval = test_interval_q;

endmodule

// File: tb/tb_dma_perf_monitor.sv
// tb_dma_perf_monitor: directed and randomized checks of dma_perf_monitor.
// The reference model tracks each channel's phase and its elapsed cycles as
// unbounded integers and clips recorded values at the statistic maximum.
module tb_dma_perf_monitor;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 4;
   localparam int MAXV   = (1 << CNT_W) - 1;
   localparam int S_IDLE = 0;
   localparam int S_BUSY = 1;
   localparam int S_GAP  = 2;

   // ---------------- clock / reset / DUT ----------------
   logic              clk_pcie = 1'b0;
   logic              rst_pcie;
   logic [NUM_CH-1:0] dma_write_start;
   logic [NUM_CH-1:0] dma_write_end;
   logic              stat_clear;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [2:0]        rd_sel;
   logic [CNT_W-1:0]  rd_data;
   logic              rd_valid;
   logic              test_interval;

   always #5 clk_pcie = ~clk_pcie;

   dma_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
      .clk_pcie        (clk_pcie),
      .rst_pcie        (rst_pcie),
      .dma_write_start (dma_write_start),
      .dma_write_end   (dma_write_end),
      .stat_clear      (stat_clear),
      .rd_en           (rd_en),
      .rd_ch           (rd_ch),
      .rd_sel          (rd_sel),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .test_interval   (test_interval)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_state [NUM_CH];
   int m_k     [NUM_CH];   // cycles already spent in the current BUSY/GAP stretch
   int m_last  [NUM_CH];
   int m_min   [NUM_CH];
   int m_max   [NUM_CH];
   int m_gmax  [NUM_CH];
   int m_xfer  [NUM_CH];
   int m_err   [NUM_CH];
   int m_sat   [NUM_CH];
   logic [CNT_W-1:0] exp_q[$];   // expected rd_data, one entry per cycle
   int m_rd_data;
   int m_rd_valid;
   int m_ti;

   function automatic int clip(input int v);
      return (v > MAXV) ? MAXV : v;
   endfunction

   function automatic int mval(input int ch, input int sel);
      if (ch >= NUM_CH) return 0;
      case (sel)
         0: return m_last[ch];
         1: return m_min[ch];
         2: return m_max[ch];
         3: return m_gmax[ch];
         4: return m_xfer[ch];
         5: return m_sat[ch] * 8 + m_err[ch] * 4 + m_state[ch];
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_state[c] = S_IDLE; m_k[c] = 0;
         m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0; m_gmax[c] = 0;
         m_xfer[c] = 0; m_err[c] = 0; m_sat[c] = 0;
      end
      m_rd_data = 0; m_rd_valid = 0; m_ti = 1;
      exp_q.delete();
      exp_q.push_back('0);
   endtask

   task automatic model_step();
      int ti_next;
      // Reads and the activity flag see the statistics from before this edge.
      if (rd_en) m_rd_data = mval(int'(rd_ch), int'(rd_sel));
      m_rd_valid = int'(rd_en);
      ti_next = 1;
      for (int c = 0; c < NUM_CH; c++)
         if (m_max[c] != 0 || m_gmax[c] != 0) ti_next = 0;
      m_ti = ti_next;
      for (int c = 0; c < NUM_CH; c++) begin
         int k, len;
         bit st, en, rec_b, rec_g, err_ev, sat_ev;
         k = m_k[c] + 1;
         st = dma_write_start[c];
         en = dma_write_end[c];
         rec_b = 0; rec_g = 0; err_ev = 0; sat_ev = 0; len = 0;
         if (m_state[c] == S_IDLE) begin
            if (st) begin m_state[c] = S_BUSY; m_k[c] = 0; end
         end else if (m_state[c] == S_BUSY) begin
            if (en) begin
               rec_b = 1; len = clip(k); sat_ev = (k > MAXV); m_k[c] = 0;
               if (!st) m_state[c] = S_GAP;
            end else if (st) begin
               err_ev = 1; m_k[c] = 0;
            end else begin
               sat_ev = (k > MAXV); m_k[c] = k;
            end
         end else begin
            sat_ev = (k > MAXV);
            if (st) begin
               rec_g = 1; len = clip(k); m_state[c] = S_BUSY; m_k[c] = 0;
            end else begin
               m_k[c] = k;
            end
         end
         if (stat_clear) begin
            m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0; m_gmax[c] = 0;
            m_xfer[c] = 0; m_err[c] = 0; m_sat[c] = 0;
         end else begin
            if (rec_b) begin
               m_last[c] = len;
               if (len < m_min[c]) m_min[c] = len;
               if (len > m_max[c]) m_max[c] = len;
               if (m_xfer[c] == MAXV) sat_ev = 1;
               else m_xfer[c]++;
            end
            if (rec_g && len > m_gmax[c]) m_gmax[c] = len;
            if (err_ev) m_err[c] = 1;
            if (sat_ev) m_sat[c] = 1;
         end
      end
      exp_q.delete();
      exp_q.push_back(CNT_W'(m_rd_data));
   endtask

   always @(posedge clk_pcie) begin
      if (!rst_pcie) model_step();
   end

   // ---------------- compare process ----------------
   always @(negedge clk_pcie) begin
      if (chk_en) begin
         check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
         check("rd_data", 32'(rd_data), 32'(exp_q[0]));
         check("test_interval", 32'(test_interval), 32'(m_ti));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk_pcie);
      #1;
      dma_write_start = '0;
      dma_write_end   = '0;
      stat_clear      = 1'b0;
      rd_en           = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic ev(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] e, input bit clr);
      dma_write_start = s;
      dma_write_end   = e;
      stat_clear      = clr;
      cyc();
   endtask

   task automatic do_read(input int ch, input int sel, input string name, input logic [31:0] exp);
      rd_en  = 1'b1;
      rd_ch  = CH_W'(ch);
      rd_sel = 3'(sel);
      cyc();
      check({name, "_vld"}, 32'(rd_valid), 32'd1);
      check(name, 32'(rd_data), exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_pcie = 1'b1;
      dma_write_start = '0; dma_write_end = '0; stat_clear = 1'b0;
      rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
      model_reset();
      chk_en = 1'b1;
      #1;
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_ti", 32'(test_interval), 32'd1);
      repeat (3) @(posedge clk_pcie);
      #1;
      rst_pcie = 1'b0;
      do_read(0, 1, "rst_min", 32'd255);
      do_read(0, 4, "rst_xfer", 32'd0);

      // Single transfer on ch0: start, four busy cycles, end -> length 5
      ev(4'b0001, 4'b0000, 0);
      idle(4);
      ev(4'b0000, 4'b0001, 0);
      check("t1_ti_hold", 32'(test_interval), 32'd1);
      cyc();
      check("t1_ti_fall", 32'(test_interval), 32'd0);
      do_read(0, 0, "t1_last", 32'd5);
      do_read(0, 1, "t1_min", 32'd5);
      do_read(0, 2, "t1_max", 32'd5);
      do_read(0, 4, "t1_xfer", 32'd1);
      do_read(0, 5, "t1_status", 32'd2);

      // Gap on ch1: start@0 end@3 start@10 end@20
      ev(4'b0010, 4'b0000, 0);
      idle(2);
      ev(4'b0000, 4'b0010, 0);
      idle(6);
      ev(4'b0010, 4'b0000, 0);
      idle(9);
      ev(4'b0000, 4'b0010, 0);
      do_read(1, 3, "t2_gmax", 32'd7);
      do_read(1, 1, "t2_min", 32'd3);
      do_read(1, 2, "t2_max", 32'd10);
      do_read(1, 4, "t2_xfer", 32'd2);

      // Back-to-back on ch2: L=3, G=4, then start+end same cycle (L=2), then L=3
      ev(4'b0100, 4'b0000, 0);
      idle(2);
      ev(4'b0000, 4'b0100, 0);
      idle(3);
      ev(4'b0100, 4'b0000, 0);
      idle(1);
      ev(4'b0100, 4'b0100, 0);
      idle(2);
      ev(4'b0000, 4'b0100, 0);
      do_read(2, 4, "t3_xfer", 32'd3);
      do_read(2, 3, "t3_gmax", 32'd4);
      do_read(2, 1, "t3_min", 32'd2);

      // Start while BUSY on ch2 -> err, state BUSY
      ev(4'b0100, 4'b0000, 0);
      idle(2);
      ev(4'b0100, 4'b0000, 0);
      do_read(2, 5, "t3_err_status", 32'd5);

      // Stray end on idle ch3
      ev(4'b0000, 4'b1000, 0);
      do_read(3, 4, "t3_stray_xfer", 32'd0);
      do_read(3, 5, "t3_stray_status", 32'd0);
      do_read(3, 1, "t3_stray_min", 32'd255);

      // Saturation on ch3: 300 busy cycles
      ev(4'b1000, 4'b0000, 0);
      idle(299);
      ev(4'b0000, 4'b1000, 0);
      do_read(3, 0, "t4_last", 32'd255);
      do_read(3, 5, "t4_status", 32'd10);
      do_read(3, 4, "t4_xfer", 32'd1);

      // Clear in the same cycle as an end on ch0
      ev(4'b0001, 4'b0000, 0);
      idle(2);
      ev(4'b0000, 4'b0001, 1);
      do_read(0, 2, "t5_max", 32'd0);
      do_read(0, 1, "t5_min", 32'd255);
      do_read(0, 4, "t5_xfer", 32'd0);
      do_read(0, 5, "t5_status", 32'd2);
      do_read(3, 5, "t5_ch3_status", 32'd2);

      // Read port boundaries
      do_read(NUM_CH, 2, "t6_oob", 32'd0);
      do_read(0, 6, "t6_sel6", 32'd0);
      do_read(0, 1, "t6_min", 32'd255);
      cyc();
      check("t6_valid_low", 32'(rd_valid), 32'd0);
      check("t6_data_hold", 32'(rd_data), 32'd255);

      // Async reset mid-BUSY on ch1 with test_interval low
      ev(4'b0010, 4'b0000, 0);
      idle(2);
      ev(4'b0000, 4'b0010, 0);
      idle(2);
      ev(4'b0010, 4'b0000, 0);
      idle(3);
      check("t7_ti_pre", 32'(test_interval), 32'd0);
      rst_pcie = 1'b1;
      model_reset();
      #1;
      check("t7_rd_data", 32'(rd_data), 32'd0);
      check("t7_rd_valid", 32'(rd_valid), 32'd0);
      check("t7_ti", 32'(test_interval), 32'd1);
      idle(2);
      rst_pcie = 1'b0;
      do_read(1, 5, "t7_status", 32'd0);
      do_read(1, 4, "t7_xfer", 32'd0);

      // Randomized traffic: dense phase then sparse phase for long stretches
      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (ph == 0) begin
                  dma_write_start[c] = ($urandom_range(0, 5) == 0);
                  dma_write_end[c]   = ($urandom_range(0, 3) == 0);
               end else begin
                  dma_write_start[c] = ($urandom_range(0, 299) == 0);
                  dma_write_end[c]   = ($urandom_range(0, 199) == 0);
               end
            end
            stat_clear = ($urandom_range(0, 399) == 0);
            rd_en  = 1'($urandom_range(0, 1));
            rd_ch  = CH_W'($urandom_range(0, NUM_CH + 1));
            rd_sel = 3'($urandom_range(0, 7));
            @(posedge clk_pcie);
            #1;
         end
      end
      dma_write_start = '0; dma_write_end = '0; stat_clear = 1'b0; rd_en = 1'b0;

      // Final sweep of every statistic on every channel
      for (int c = 0; c <= NUM_CH; c++) begin
         for (int s = 0; s < 8; s++) begin
            rd_en = 1'b1; rd_ch = CH_W'(c); rd_sel = 3'(s);
            cyc();
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
